fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe_if.sv | 30 +++
 rtl/fp_mul_pipe.sv | 170 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if -- operand/result handshake bundle for fp_mul_pipe.
//   in_valid/in_ready/a/b        : operand transfer (upstream -> multiplier)
//   out_valid/out_ready/result/flags : result transfer (multiplier -> downstream)
//   flags = {invalid, overflow, underflow, inexact}
// Modports: master = bench/upstream side, slave = the multiplier.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- pipelined IEEE-style floating-point multiplier.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : fp_mul_pipe_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/result/flags)
// Parameters: EXP_W exponent width, MAN_W stored mantissa width, STAGES depth (2..8).
// Stage 0 decodes operands and forms the significand product; stage 1 normalises,
// rounds and packs; remaining stages are delay registers. The whole pipe moves
// only when the output register is empty or being drained.
// Denormal operands are flushed to zero.
// Build option: define FP_MUL_PIPE_RNE_EN for round-to-nearest-even; otherwise
// results are truncated toward zero (inexact is reported either way).
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 3
) (
  input logic          clk,
  input logic          rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int XW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam int unsigned NS = STAGES;
  localparam logic signed [XW-1:0] BIAS    = XW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'(2 ** EXP_W - 1);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  logic adv;

  // operand decode
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  cls_t cls_d;
  logic inv_d;
  logic signed [XW-1:0] exp_d;
  logic [PW-1:0] prod_d;

  // stage 0 registers
  logic [NS-1:0]        vld_q;
  logic                 sign_q;
  logic signed [XW-1:0] exp_q;
  logic [PW-1:0]        prod_q;
  cls_t                 cls_q;
  logic                 inv_q;

  // stage 1 datapath
  logic [PW-1:0]        norm;
  logic [MAN_W:0]       sig;
  logic                 guard, sticky, inexact, round_up, carry;
  logic [MAN_W+1:0]     sig_r;
  logic [MAN_W-1:0]     man_f;
  logic signed [XW-1:0] exp_n, exp_f;
  logic [W-1:0]         res_c;
  logic [3:0]           flg_c;

  // stages 1..STAGES-1 hold packed result/flags
  logic [W-1:0] res_q [1:STAGES-1];
  logic [3:0]   flg_q [1:STAGES-1];

  assign adv           = !vld_q[NS-1] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[NS-1];
  assign bus.result    = res_q[STAGES-1];
  assign bus.flags     = flg_q[STAGES-1];

  assign ea = bus.a[W-2:MAN_W];
  assign eb = bus.b[W-2:MAN_W];
  assign ma = bus.a[MAN_W-1:0];
  assign mb = bus.b[MAN_W-1:0];

  assign exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign prod_d = PW'({1'b1, ma}) * PW'({1'b1, mb});

  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (&ea) && (|ma);
    b_nan  = (&eb) && (|mb);
    a_inf  = (&ea) && !(|ma);
    b_inf  = (&eb) && !(|mb);
    cls_d  = CLS_NORM;
    inv_d  = 1'b0;
    if (a_nan || b_nan) begin
      cls_d = CLS_NAN;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      cls_d = CLS_NAN;
      inv_d = 1'b1;
    end else if (a_inf || b_inf) begin
      cls_d = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls_d = CLS_ZERO;
    end
  end

  // Pre-shifting the unnormalised product by one lets both cases share the
  // same significand/guard/sticky bit positions.
  always_comb begin
    norm    = prod_q[PW-1] ? prod_q : (prod_q << 1);
    sig     = norm[PW-1:MAN_W+1];
    guard   = norm[MAN_W];
    sticky  = |norm[MAN_W-1:0];
    inexact = guard | sticky;
    exp_n   = exp_q + {{(XW-1){1'b0}}, prod_q[PW-1]};
`ifdef FP_MUL_PIPE_RNE_EN
    round_up = guard & (sticky | sig[0]);
`else
    round_up = 1'b0;
`endif
    sig_r = {1'b0, sig} + {{(MAN_W+1){1'b0}}, round_up};
    carry = sig_r[MAN_W+1];
    man_f = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    exp_f = exp_n + {{(XW-1){1'b0}}, carry};

    res_c = '0;
    flg_c = '0;
    case (cls_q)
      CLS_NAN: begin
        res_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flg_c = {inv_q, 3'b000};
      end
      CLS_INF:  res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: res_c = {sign_q, {(W-1){1'b0}}};
      default: begin
        if (exp_f >= EXP_MAX) begin
          res_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg_c = 4'b0101;
        end else if (exp_f[XW-1] || (exp_f == '0)) begin
          res_c = {sign_q, {(W-1){1'b0}}};
          flg_c = 4'b0011;
        end else begin
          res_c = {sign_q, exp_f[EXP_W-1:0], man_f};
          flg_c = {3'b000, inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      prod_q <= '0;
      cls_q  <= CLS_ZERO;
      inv_q  <= 1'b0;
      for (int unsigned i = 1; i < NS; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else if (adv) begin
      vld_q <= {vld_q[NS-2:0], bus.in_valid};
      if (bus.in_valid) begin
        sign_q <= bus.a[W-1] ^ bus.b[W-1];
        exp_q  <= exp_d;
        prod_q <= prod_d;
        cls_q  <= cls_d;
        inv_q  <= inv_d;
      end
      res_q[1] <= res_c;
      flg_q[1] <= flg_c;
      for (int unsigned i = 2; i < NS; i++) begin
        res_q[i] <= res_q[i-1];
        flg_q[i] <= flg_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe -- self-checking bench for fp_mul_pipe (EXP_W=8, MAN_W=23, STAGES=3).
// A transaction-level model tracks each accepted operation and its position in
// the pipe; expected products come from directed constants or an integer
// reference multiplier.
module tb_fp_mul_pipe;
  localparam int STAGES = 3;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          pos;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_out    = 0;
  bit rnd_ready = 0;
  bit rnd_gaps  = 0;
  item_t pend[$];
  item_t fl[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference multiplier: integer significand product, remainder-based rounding.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    bit an, bn, ai, bi, az, bz, inx;
    longint unsigned ma, mb, p, q, rem, half;
    int e, shift;
    s  = a[31] ^ b[31];
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    if (an || bn) return {4'b0000, 32'h7FC00000};
    if ((ai && bz) || (az && bi)) return {4'b1000, 32'h7FC00000};
    if (ai || bi) return {4'b0000, s, 8'hFF, 23'h0};
    if (az || bz) return {4'b0000, s, 31'h0};
    ma = 64'(a[22:0]) | 64'h800000;
    mb = 64'(b[22:0]) | 64'h800000;
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    shift = 23;
    if (p >= (64'd1 << 47)) begin
      shift = 24;
      e++;
    end
    q    = p >> shift;
    rem  = p & ((64'd1 << shift) - 1);
    half = 64'd1 << (shift - 1);
    inx  = (rem != 0);
`ifdef FP_MUL_PIPE_RNE_EN
    if (rem > half || (rem == half && q[0])) q++;
`endif
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, inx, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [31:0] m;
    int r;
    r = $urandom_range(15);
    m = $urandom;
    case (r)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; if ($urandom_range(1) == 0) m = 0; end
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      4:       begin e = 8'($urandom_range(120, 134)); m = 32'h7FFFFF - 32'($urandom_range(3)); end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(1)), e, m[22:0]};
  endfunction

  task automatic push_dir(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic [3:0] flg);
    item_t it;
    it.a = a; it.b = b; it.res = res; it.flg = flg; it.pos = 0;
    pend.push_back(it);
  endtask

  task automatic push_rnd();
    item_t it;
    logic [35:0] r;
    it.a = rnd_op();
    it.b = rnd_op();
    r = ref_mul(it.a, it.b);
    it.res = r[31:0];
    it.flg = r[35:32];
    it.pos = 0;
    pend.push_back(it);
  endtask

  // One clock cycle: drive, check against the model, advance the model, clock.
  task automatic cycle();
    bit offer, exp_ov, exp_rdy;
    item_t it;
    if (rnd_ready) bus.out_ready = ($urandom_range(3) != 0);
    offer = (pend.size() > 0) && (!rnd_gaps || $urandom_range(3) != 0);
    if (offer) begin
      bus.in_valid = 1'b1;
      bus.a = pend[0].a;
      bus.b = pend[0].b;
    end else begin
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
    end
    #1;
    exp_ov  = (fl.size() > 0) && (fl[0].pos == STAGES - 1);
    exp_rdy = !exp_ov || bus.out_ready;
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (exp_ov) begin
      chk("result", 64'(bus.result), 64'(fl[0].res));
      chk("flags", 64'(bus.flags), 64'(fl[0].flg));
    end
    if (exp_rdy) begin
      if (exp_ov) begin
        void'(fl.pop_front());
        n_out++;
      end
      foreach (fl[i]) fl[i].pos++;
      if (offer) begin
        it = pend.pop_front();
        it.pos = 0;
        fl.push_back(it);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (fl.size() > 0 || pend.size() > 0); k++) cycle();
    chk("drain_empty", 64'(fl.size() + pend.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int out0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a = '0;
    bus.b = '0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags", 64'(bus.flags), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // latency of a single op on an idle pipe
    push_dir(32'h40000000, 32'h40900000, 32'h41100000, 4'b0000);
    cycle();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk("latency", 64'(lat), 64'(STAGES));
    drain(20);

    // special cases and boundaries, back to back
    push_dir(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    push_dir(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    push_dir(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    push_dir(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
`ifdef FP_MUL_PIPE_RNE_EN
    push_dir(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
    push_dir(32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001);
`else
    push_dir(32'h3F800001, 32'h3FC00000, 32'h3FC00001, 4'b0001);
    push_dir(32'h3FFFFFFE, 32'h3F800001, 32'h3FFFFFFF, 4'b0001);
`endif
    push_dir(32'h7FC12345, 32'h00000000, 32'h7FC00000, 4'b0000);
    push_dir(32'h7F800000, 32'h7FC00001, 32'h7FC00000, 4'b0000);
    push_dir(32'h80000000, 32'h7F800000, 32'h7FC00000, 4'b1000);
    push_dir(32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
    push_dir(32'h80400000, 32'h3F800000, 32'h80000000, 4'b0000);
    drain(100);

    // backpressure: 5 ops, out_ready low for 6 cycles
    out0 = n_out;
    bus.out_ready = 1'b0;
    repeat (5) push_rnd();
    repeat (6) cycle();
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    chk("stall_pending", 64'(pend.size()), 64'd2);
    bus.out_ready = 1'b1;
    drain(50);
    chk("stall_delivered", 64'(n_out - out0), 64'd5);

    // randomized traffic with gaps and random backpressure
    rnd_ready = 1;
    rnd_gaps  = 1;
    repeat (250) push_rnd();
    drain(3000);
    rnd_ready = 0;
    rnd_gaps  = 0;
    bus.out_ready = 1'b1;

    // reset with ops in flight
    repeat (3) push_rnd();
    repeat (3) cycle();
    chk("inflight_count", 64'(fl.size()), 64'd3);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_result", 64'(bus.result), 64'd0);
    chk("mid_rst_flags", 64'(bus.flags), 64'd0);
    fl.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (5) cycle();
    push_dir(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    cycle();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk("post_rst_latency", 64'(lat), 64'(STAGES));
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
